adc_spi_responder: RTL and testbench

- Synthesizable SPI slave that emulates the 8-channel, 12-bit serial ADC on the board: it receives SCLK/CS/DIN from the ADC reader and drives DOUT.
- Used for FPGA loopback and bench closure of the ADC-read → PID → DAC chain without the physical converter.
- Sample values come from a parallel input bus: fixed test values or a DAC-driven plant model.
- All SPI inputs are oversampled on the system clock; there are no SCLK-clocked flops.

---
 rtl/adc_spi_responder.sv | 149 ++++++++++++++
 tb/tb_adc_spi_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// SPI slave emulating an 8-channel, 12-bit serial ADC. Every SPI input is
// oversampled on clk; the frame bits are selected from a snapshot of the
// chosen channel and presented on spi_dout from a register.
module adc_spi_responder #(
  parameter int NUM_CH = 8,
  parameter int DW     = 12,
  parameter int LEAD   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_sclk,
  input  logic                 spi_cs,
  input  logic                 spi_din,
  output logic                 spi_dout,
  input  logic [NUM_CH*DW-1:0] sample_data,
  output logic [2:0]           ch_sel,
  output logic                 sample_req,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam int FW = LEAD + DW;
  localparam int CW = $clog2(FW + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  // Synchronizer chains: [0] first flop, [1] second, [2] third (edge history)
  logic [2:0]    sclk_sync_q, sclk_sync_d;
  logic [2:0]    cs_sync_q, cs_sync_d;
  logic [1:0]    din_sync_q, din_sync_d;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [FW-1:0] snap_q, snap_d;
  logic          dout_q, dout_d;
  logic [2:0]    ch_sel_q, ch_sel_d;
  logic          sample_req_q, sample_req_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;

  logic          sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DW-1:0] cur_sample;
  logic [FW-1:0] snap_shifted;

  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise    = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall    = ~cs_sync_q[1] & cs_sync_q[2];
  assign cur_sample = sample_data[int'(ch_sel_q) * DW +: DW];
  // Bit (bit_cnt+1) of the frame sits at the top after shifting by bit_cnt
  assign snap_shifted = snap_q << bit_cnt_q;

  // Next-state logic: CS edges take priority and drop any same-cycle SCLK edge
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], spi_sclk};
    cs_sync_d    = {cs_sync_q[1:0], spi_cs};
    din_sync_d   = {din_sync_q[0], spi_din};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    cmd_d        = cmd_q;
    snap_d       = snap_q;
    dout_d       = dout_q;
    ch_sel_d     = ch_sel_q;
    sample_req_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        dout_d = 1'b0;
        if (cs_fall) begin
          state_d      = S_ACTIVE;
          bit_cnt_d    = '0;
          cmd_d        = '0;
          snap_d       = {{LEAD{1'b0}}, cur_sample};
          dout_d       = snap_d[FW-1];
          sample_req_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
          if (bit_cnt_q == CW'(FW)) begin
            frame_done_d = 1'b1;
            ch_sel_d     = 3'(int'(cmd_q) % NUM_CH);
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (!cs_fall) begin
          if (sclk_rise) begin
            if (bit_cnt_q != CW'(FW)) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              // Rising edges 3, 4 and 5 carry ADD2, ADD1, ADD0
              if (bit_cnt_q >= CW'(2) && bit_cnt_q <= CW'(4)) begin
                cmd_d = {cmd_q[1:0], din_sync_q[1]};
              end
            end
          end else if (sclk_fall) begin
            if (bit_cnt_q < CW'(FW)) begin
              dout_d = snap_shifted[FW-1];
            end else begin
              dout_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= 3'b111;
      cs_sync_q    <= 3'b000;
      din_sync_q   <= 2'b00;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      cmd_q        <= '0;
      snap_q       <= '0;
      dout_q       <= 1'b0;
      ch_sel_q     <= '0;
      sample_req_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      din_sync_q   <= din_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      cmd_q        <= cmd_d;
      snap_q       <= snap_d;
      dout_q       <= dout_d;
      ch_sel_q     <= ch_sel_d;
      sample_req_q <= sample_req_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign spi_dout   = dout_q;
  assign ch_sel     = ch_sel_q;
  assign sample_req = sample_req_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a table of SPI frames with hand-computed
// results, then a hand-written reset-in-mid-frame sequence.
module tb_adc_spi_responder;

  localparam int NUM_CH = 8;
  localparam int DW     = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 spi_sclk;
  logic                 spi_cs;
  logic                 spi_din;
  logic                 spi_dout;
  logic [NUM_CH*DW-1:0] sample_data;
  logic [2:0]           ch_sel;
  logic                 sample_req;
  logic                 frame_done;
  logic                 frame_err;

  int total = 0;
  int bad   = 0;
  int req_cnt, done_cnt, err_cnt;

  // Clock / reset
  always #5 clk = ~clk;

  adc_spi_responder #(.NUM_CH(NUM_CH), .DW(DW), .LEAD(4)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
    .spi_din(spi_din), .spi_dout(spi_dout), .sample_data(sample_data),
    .ch_sel(ch_sel), .sample_req(sample_req), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  // Pulse counters, sampled on the inactive clock edge
  always @(negedge clk) begin
    if (sample_req) req_cnt++;
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  typedef struct {
    logic [DW-1:0] ch0;
    logic [DW-1:0] ch3;
    logic [DW-1:0] ch5;
    logic [2:0]    addr;
    int            n_rise;
    int            chg_rise;
    logic [DW-1:0] chg_val;
    logic [15:0]   exp_word;
    int            exp_done;
    int            exp_err;
    logic [2:0]    exp_ch;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    sample_data[k*DW +: DW] = v;
  endtask

  task automatic clear_counts();
    req_cnt  = 0;
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Driver: one frame with n rising edges; bit i is captured at rx[20-i]
  task automatic do_frame(input int n, input logic [2:0] addr, input int chg_rise,
                          input logic [DW-1:0] chg_val, output logic [19:0] rx);
    rx = '0;
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      spi_sclk = 1'b0;
      spi_din  = (i >= 3 && i <= 5) ? addr[5-i] : 1'b0;
      repeat (4) @(negedge clk);
      rx[20-i] = spi_dout;
      spi_sclk = 1'b1;
      if (i == chg_rise) set_ch(0, chg_val);
      repeat (4) @(negedge clk);
    end
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [19:0] exp_bits(input logic [15:0] w, input int n);
    logic [19:0] r;
    r = '0;
    for (int i = 1; i <= n; i++) r[20-i] = (i <= 16) ? w[16-i] : 1'b0;
    return r;
  endfunction

  initial begin
    logic [19:0] rx;
    int ones;

    vecs[0] = '{12'hA5C, 12'h000, 12'h000, 3'd0, 16, 0, 12'h000, 16'h0A5C, 1, 0, 3'd0};
    vecs[1] = '{12'h001, 12'h000, 12'h7FF, 3'd5, 16, 0, 12'h000, 16'h0001, 1, 0, 3'd5};
    vecs[2] = '{12'h001, 12'h000, 12'h7FF, 3'd0, 16, 0, 12'h000, 16'h07FF, 1, 0, 3'd0};
    vecs[3] = '{12'hFC0, 12'h000, 12'h7FF, 3'd3, 10, 0, 12'h000, 16'h0FC0, 0, 1, 3'd0};
    vecs[4] = '{12'h3C3, 12'h000, 12'h7FF, 3'd0, 16, 0, 12'h000, 16'h03C3, 1, 0, 3'd0};
    vecs[5] = '{12'h3C3, 12'hABC, 12'h7FF, 3'd3, 20, 0, 12'h000, 16'h03C3, 1, 0, 3'd3};
    vecs[6] = '{12'h3C3, 12'hABC, 12'h7FF, 3'd0, 16, 0, 12'h000, 16'h0ABC, 1, 0, 3'd0};
    vecs[7] = '{12'h123, 12'hABC, 12'h7FF, 3'd0, 16, 8, 12'hFFF, 16'h0123, 1, 0, 3'd0};
    vecs[8] = '{12'hFFF, 12'hABC, 12'h7FF, 3'd2, 16, 0, 12'h000, 16'h0FFF, 1, 0, 3'd2};

    rst_n = 1'b0;
    spi_sclk = 1'b1;
    spi_cs = 1'b1;
    spi_din = 1'b0;
    sample_data = '0;
    clear_counts();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    check("reset_dout", {31'd0, spi_dout}, 32'd0);
    check("reset_ch_sel", {29'd0, ch_sel}, 32'd0);
    check("reset_pulses", req_cnt + done_cnt + err_cnt, 32'd0);

    for (int v = 0; v < 9; v++) begin
      set_ch(0, vecs[v].ch0);
      set_ch(3, vecs[v].ch3);
      set_ch(5, vecs[v].ch5);
      clear_counts();
      do_frame(vecs[v].n_rise, vecs[v].addr, vecs[v].chg_rise, vecs[v].chg_val, rx);
      check($sformatf("v%0d_dout_bits", v), {12'd0, rx}, {12'd0, exp_bits(vecs[v].exp_word, vecs[v].n_rise)});
      check($sformatf("v%0d_sample_req", v), req_cnt, 32'd1);
      check($sformatf("v%0d_frame_done", v), done_cnt, vecs[v].exp_done);
      check($sformatf("v%0d_frame_err", v), err_cnt, vecs[v].exp_err);
      check($sformatf("v%0d_ch_sel", v), {29'd0, ch_sel}, {29'd0, vecs[v].exp_ch});
    end

    // Reset in mid-frame with CS held low through the release
    set_ch(0, 12'h5A5);
    set_ch(2, 12'h111);
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      spi_sclk = 1'b0;
      spi_din  = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    clear_counts();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    repeat (8) begin
      @(negedge clk);
      if (spi_dout) ones++;
    end
    for (int i = 0; i < 4; i++) begin
      spi_sclk = 1'b0;
      repeat (4) @(negedge clk);
      if (spi_dout) ones++;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      if (spi_dout) ones++;
    end
    check("rst_mid_dout_zero", ones, 32'd0);
    check("rst_mid_no_req", req_cnt, 32'd0);
    check("rst_mid_no_done_err", done_cnt + err_cnt, 32'd0);
    check("rst_mid_ch_sel", {29'd0, ch_sel}, 32'd0);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_cs_release_no_pulse", done_cnt + err_cnt, 32'd0);
    clear_counts();
    do_frame(16, 3'd0, 0, 12'h000, rx);
    check("post_rst_dout_bits", {12'd0, rx}, {12'd0, exp_bits(16'h05A5, 16)});
    check("post_rst_sample_req", req_cnt, 32'd1);
    check("post_rst_frame_done", done_cnt, 32'd1);
    check("post_rst_frame_err", err_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
